free_list: RTL
==============

// Module: free_list
// PURPOSE
//  Circular FIFO of unallocated physical register indices for the OoO rename stage.
//  Dispatch pops one tag per renaming instruction and drives it to the RAT as pd_dispatch.
//  Commit pushes the stale physical register released by the RRAT back into the list.
//  On a branch flush, the speculative head pointer rewinds to the retire head.
//  This returns every tag allocated by a squashed instruction.
// PARAMETERS
//  PHYS_REG_BITS  6   width of a physical register tag
//  NUM_PHYS_REGS  64  total physical registers; p0..p31 hold the reset arch mapping
//  DEPTH          NUM_PHYS_REGS-32 = 32   free-list capacity
//  PTR_BITS       $clog2(DEPTH)+1   pointer width, including the wrap bit
// PORTS
//  clk          in   1              clock
//  rst          in   1              reset: synchronous, active-high
//  dequeue      in   1              dispatch allocates the head tag this cycle
//  pd_out       out  PHYS_REG_BITS  tag at spec head; valid only when !empty
//  empty        out  1              no free tag available
//  enqueue      in   1              commit frees pd_free_in
//  pd_free_in   in   PHYS_REG_BITS  freed tag (old RRAT mapping of the committed rd)
//  commit_alloc in   1              committing instr had consumed a tag; advances retire head
//  flush        in   1              global_branch_signal: rewind spec head to retire head
//  full         out  1              all DEPTH entries free
//  count        out  PTR_BITS       number of free tags (tail - spec_head)
// BEHAVIOUR
//  - State: mem[DEPTH], spec_head, retire_head, tail (all PTR_BITS wide, modulo 2*DEPTH).
//  - Reset: mem[i]=32+i; spec_head=retire_head=0; tail=DEPTH (wrap bit set).
//    Outputs after reset: full=1, empty=0, count=DEPTH, pd_out=32.
//  - pd_out=mem[spec_head[PTR_BITS-2:0]] is combinational (0-cycle); dispatch uses it the same cycle.
//    spec_head increments at the next edge when dequeue && !empty && !flush.
//  - dequeue while empty: ignored (no pointer move). Dispatch must stall on empty.
//    No same-cycle bypass of enqueue into pd_out.
//  - enqueue && pd_free_in!=0: mem[tail idx]<=pd_free_in; tail++.
//    An enqueue of p0 is dropped, because x0 is never renamed.
//  - enqueue while full: illegal (a simulation assertion fires); tail does not move.
//  - commit_alloc: retire_head++. A commit that frees a tag always had alloc'd one, so commit_alloc=enqueue.
//  - flush: spec_head <= retire_head + commit_alloc (same-cycle commit is older than the flush and is honoured).
//    - enqueue in the flush cycle is also honoured.
//    - dequeue in the flush cycle is ignored.
//  - Derived outputs: empty = (tail==spec_head). full = (count==DEPTH).
//    count = tail - spec_head, modulo 2^PTR_BITS.
//  - Wrap-around: pointers increment modulo 2*DEPTH; the index is ptr[PTR_BITS-2:0].
//  - Simultaneous dequeue+enqueue when non-empty: both apply, and count is unchanged.
//  - rst overrides all inputs, including a rst asserted mid-flush or mid-operation.
//  - Invariant (assert): retire_head <= spec_head <= tail, in modulo order.
// TESTING
//  1 Reset, then 32 consecutive dequeues.
//    -> pd_out sequence 32..63, then empty=1, count=0.
//    A 33rd dequeue leaves the pointers unchanged.
//  2 From reset, dequeue 3 (tags 32,33,34), then commit_alloc+enqueue of 5.
//    -> count=30 and tail idx=1. mem[0]=5 is reached after 29 more pops.
//  3 Dequeue 4, commit_alloc 1 (enqueue 7), then flush.
//    -> spec_head=retire_head=1, count=32, and pd_out=33.
//  4 Flush in the same cycle as commit_alloc+enqueue(9) and dequeue.
//    -> the dequeue is ignored, tail advances, and spec_head = old retire_head+1.
//  5 Empty list, with dequeue and enqueue(12) in the same cycle.
//    -> the dequeue is ignored; next cycle empty=0 and pd_out=12.
//  6 Enqueue pd_free_in=0 -> no change. Enqueue when full -> the assertion fires.
//    Assert rst mid-stream -> the reset state is restored next cycle.

Source files
------------

// File: rtl/free_list.sv
// Circular free list of physical register tags for the rename stage.
// It keeps a speculative head for dispatch, a retire head for commit, and a tail where freed tags return.
module free_list #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_PHYS_REGS = 64,
  parameter int DEPTH         = NUM_PHYS_REGS - 32,
  parameter int PTR_BITS      = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dequeue,
  output logic [PHYS_REG_BITS-1:0] pd_out,
  output logic                     empty,
  input  logic                     enqueue,
  input  logic [PHYS_REG_BITS-1:0] pd_free_in,
  input  logic                     commit_alloc,
  input  logic                     flush,
  output logic                     full,
  output logic [PTR_BITS-1:0]      count
);

  logic [PHYS_REG_BITS-1:0] mem [DEPTH];
  logic [PTR_BITS-1:0]      spec_head, retire_head, tail;
  logic [PTR_BITS-1:0]      retire_next, spec_off, tail_off;
  logic                     deq_ok, enq_ok;

  assign count  = tail - spec_head;
  assign empty  = (tail == spec_head);
  assign full   = (count == PTR_BITS'(DEPTH));
  assign pd_out = mem[spec_head[PTR_BITS-2:0]];

  // A flush cancels the dispatch. A p0 release is dropped because x0 is never renamed.
  assign deq_ok      = dequeue && !empty && !flush;
  assign enq_ok      = enqueue && (pd_free_in != '0) && !full;
  assign retire_next = retire_head + PTR_BITS'(commit_alloc);

  assign spec_off = spec_head - retire_head;
  assign tail_off = tail - retire_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PHYS_REG_BITS'(NUM_PHYS_REGS - DEPTH + i);
      spec_head   <= '0;
      retire_head <= '0;
      tail        <= PTR_BITS'(DEPTH);
    end else begin
      if (enq_ok) begin
        mem[tail[PTR_BITS-2:0]] <= pd_free_in;
        tail                    <= tail + PTR_BITS'(1);
      end
      retire_head <= retire_next;
      // A commit in the flush cycle is older than the flush, so the rewind target includes it.
      if (flush)
        spec_head <= retire_next;
      else if (deq_ok)
        spec_head <= spec_head + PTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enqueue && (pd_free_in != '0) && full));
      assert (spec_off <= tail_off);
    end
  end

endmodule
